seq_sync_barrier: RTL and testbench

SEQ_SYNC_BARRIER -- requirements
Module: seq_sync_barrier

---
 rtl/seq_sync_pkg.sv | 29 ++
 rtl/seq_sync_timer.sv | 35 +++
 rtl/seq_sync_barrier.sv | 169 ++++++++++++++++
 tb/tb_seq_sync_barrier.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_sync_pkg.sv
// Shared types, default parameters and helpers for the sequence synchronisation barrier.
package seq_sync_pkg;

  localparam int unsigned NumChDefault  = 4;
  localparam int unsigned PhaseWDefault = 8;
  localparam int unsigned ToWDefault    = 16;

  localparam int unsigned MaxCh = 32;
  localparam int unsigned CntW  = 6;

  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StGather,
    StRelease,
    StDrain
  } state_e;

  function automatic cnt_t popcount(input logic [MaxCh-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < MaxCh; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_sync_timer.sv
// GATHER-phase cycle counter; expire_o flags the last permitted cycle before timeout.
module seq_sync_timer #(
  parameter int unsigned TO_W = seq_sync_pkg::ToWDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expire_o
);

  logic [TO_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expire_o = enable_i && (limit_i != '0) && (count_q == limit_i - TO_W'(1));

endmodule

// File: rtl/seq_sync_barrier.sv
// Multi-channel barrier: gathers per-channel arrivals, releases all-of-mask or on quorum,
// aborts on timeout, then drains until released/aborted channels drop their requests.
module seq_sync_barrier
  import seq_sync_pkg::*;
#(
  parameter int unsigned NUM_CH  = NumChDefault,
  parameter int unsigned PHASE_W = PhaseWDefault,
  parameter int unsigned TO_W    = ToWDefault
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             arrive_i,
  input  logic [NUM_CH-1:0]             mask_i,
  input  logic                          mode_i,
  input  logic [$clog2(NUM_CH+1)-1:0]   quorum_i,
  input  logic [TO_W-1:0]               timeout_i,
  output logic [NUM_CH-1:0]             release_o,
  output logic                          abort_o,
  output logic [PHASE_W-1:0]            phase_o,
  output logic [NUM_CH-1:0]             arrived_o,
  output logic                          busy_o
);

  localparam int unsigned QuorumW = $clog2(NUM_CH + 1);

  state_e               state_q, state_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic                 mode_q, mode_d;
  logic [QuorumW-1:0]   quorum_q, quorum_d;
  logic [NUM_CH-1:0]    arrived_q, arrived_d;
  logic [NUM_CH-1:0]    drain_q, drain_d;
  logic [NUM_CH-1:0]    release_q, release_d;
  logic                 abort_q, abort_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 busy_q, busy_d;

  logic [NUM_CH-1:0]    eff_mask;
  logic                 eff_mode;
  logic [QuorumW-1:0]   eff_quorum;
  logic [NUM_CH-1:0]    arrived_nx;
  cnt_t                 cnt_arr, cnt_mask, need;
  logic                 met;
  logic                 tmr_expire;

  seq_sync_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q != StGather),
    .enable_i (state_q == StGather),
    .limit_i  (timeout_i),
    .expire_o (tmr_expire)
  );

  // In IDLE the configuration being latched this cycle is already in force, which gives
  // the one-cycle release when every participant arrives together.
  always_comb begin
    if (state_q == StIdle) begin
      eff_mask   = mask_i;
      eff_mode   = mode_i;
      eff_quorum = quorum_i;
    end else begin
      eff_mask   = mask_q;
      eff_mode   = mode_q;
      eff_quorum = quorum_q;
    end
    arrived_nx = arrived_q | (arrive_i & eff_mask);
    cnt_arr    = popcount(MaxCh'(arrived_nx));
    cnt_mask   = popcount(MaxCh'(eff_mask));
    need       = (eff_quorum == '0) ? cnt_t'(1) : cnt_t'(eff_quorum);
    if (need > cnt_mask) begin
      need = cnt_mask;
    end
    met = eff_mode ? (cnt_arr >= need) : (arrived_nx == eff_mask);
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    quorum_d  = quorum_q;
    arrived_d = arrived_q;
    drain_d   = drain_q;
    release_d = '0;
    abort_d   = 1'b0;
    phase_d   = phase_q;

    unique case (state_q)
      StIdle: begin
        if (arrived_nx != '0) begin
          mask_d    = mask_i;
          mode_d    = mode_i;
          quorum_d  = quorum_i;
          arrived_d = arrived_nx;
          if (met) begin
            release_d = arrived_nx;
            drain_d   = arrived_nx;
            phase_d   = phase_q + PHASE_W'(1);
            state_d   = StRelease;
          end else begin
            state_d = StGather;
          end
        end
      end
      StGather: begin
        arrived_d = arrived_nx;
        // Release takes priority over a coincident timeout.
        if (met) begin
          release_d = arrived_nx;
          drain_d   = arrived_nx;
          phase_d   = phase_q + PHASE_W'(1);
          state_d   = StRelease;
        end else if (tmr_expire) begin
          abort_d = 1'b1;
          drain_d = arrived_nx;
          state_d = StDrain;
        end
      end
      StRelease: begin
        state_d = StDrain;
      end
      StDrain: begin
        if ((arrive_i & drain_q) == '0) begin
          arrived_d = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      quorum_q  <= '0;
      arrived_q <= '0;
      drain_q   <= '0;
      release_q <= '0;
      abort_q   <= 1'b0;
      phase_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      quorum_q  <= quorum_d;
      arrived_q <= arrived_d;
      drain_q   <= drain_d;
      release_q <= release_d;
      abort_q   <= abort_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
    end
  end

  assign release_o = release_q;
  assign abort_o   = abort_q;
  assign phase_o   = phase_q;
  assign arrived_o = arrived_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_seq_sync_barrier.sv
// Scoreboard bench for seq_sync_barrier; a second instance with PHASE_W=2 checks phase wrap.
module tb_seq_sync_barrier;

  typedef struct packed {
    logic       abort;
    logic [3:0] rel;
    logic [7:0] phase;
  } ev_t;

  logic        clk;
  logic        reset;
  logic [3:0]  arrive;
  logic [3:0]  mask;
  logic        mode;
  logic [2:0]  quorum;
  logic [15:0] timeout;

  logic [3:0]  rel1, arr1, rel2, arr2;
  logic        abort1, busy1, abort2, busy2;
  logic [7:0]  phase1;
  logic [1:0]  phase2;

  ev_t         sb_q[$];
  logic [7:0]  exp_phase;
  int          n_total;
  int          n_bad;

  seq_sync_barrier #(
    .NUM_CH  (4),
    .PHASE_W (8),
    .TO_W    (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arrive_i  (arrive),
    .mask_i    (mask),
    .mode_i    (mode),
    .quorum_i  (quorum),
    .timeout_i (timeout),
    .release_o (rel1),
    .abort_o   (abort1),
    .phase_o   (phase1),
    .arrived_o (arr1),
    .busy_o    (busy1)
  );

  seq_sync_barrier #(
    .NUM_CH  (4),
    .PHASE_W (2),
    .TO_W    (16)
  ) dut_w2 (
    .clk       (clk),
    .reset     (reset),
    .arrive_i  (arrive),
    .mask_i    (mask),
    .mode_i    (mode),
    .quorum_i  (quorum),
    .timeout_i (timeout),
    .release_o (rel2),
    .abort_o   (abort2),
    .phase_o   (phase2),
    .arrived_o (arr2),
    .busy_o    (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rel(input logic [3:0] r);
    exp_phase = exp_phase + 8'd1;
    sb_q.push_back('{abort: 1'b0, rel: r, phase: exp_phase});
  endtask

  task automatic push_abort();
    sb_q.push_back('{abort: 1'b1, rel: 4'h0, phase: exp_phase});
  endtask

  // Pop one expected event for every release/abort pulse either instance produces.
  always @(negedge clk) begin
    if (reset && (rel1 != 4'h0 || abort1 || rel2 != 4'h0 || abort2)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'({abort1, rel1}), 32'd0);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        check("sb_rel", 32'(rel1), 32'(e.rel));
        check("sb_abort", 32'(abort1), 32'(e.abort));
        check("sb_phase", 32'(phase1), 32'(e.phase));
        check("sb_rel_w2", 32'(rel2), 32'(e.rel));
        check("sb_phase_w2", 32'(phase2), 32'(e.phase[1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] acc;
    n_total   = 0;
    n_bad     = 0;
    exp_phase = 8'd0;
    reset     = 1'b0;
    arrive    = 4'h0;
    mask      = 4'hF;
    mode      = 1'b0;
    quorum    = 3'd0;
    timeout   = 16'd0;
    repeat (3) tick();
    check("rst_release", 32'(rel1), 32'd0);
    check("rst_abort", 32'(abort1), 32'd0);
    check("rst_phase", 32'(phase1), 32'd0);
    check("rst_arrived", 32'(arr1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // All-of-mask barrier, staggered arrivals on alternate cycles.
    acc = 4'h0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = 1'b1;
      arrive = acc;
      if (i == 3) push_rel(4'hF);
      tick();
      if (i < 3) begin
        check("a_arrived", 32'(arr1), 32'(acc));
        check("a_norel", 32'(rel1), 32'd0);
        check("a_busy", 32'(busy1), 32'd1);
        tick();
      end
    end
    check("a_release", 32'(rel1), 32'hF);
    check("a_phase", 32'(phase1), 32'd1);
    tick();
    check("a_pulse_end", 32'(rel1), 32'd0);
    check("a_drain_busy", 32'(busy1), 32'd1);
    arrive = 4'h0;
    tick();
    check("a_idle", 32'(busy1), 32'd0);
    check("a_cleared", 32'(arr1), 32'd0);

    // Quorum of two: ch1+ch2 release at once, ch0 waits for the next phase.
    mode   = 1'b1;
    quorum = 3'd2;
    arrive = 4'b0110;
    push_rel(4'h6);
    tick();
    check("b_release", 32'(rel1), 32'h6);
    check("b_phase", 32'(phase1), 32'd2);
    tick();
    arrive = 4'b0111;
    tick();
    check("b_drain_hold", 32'(busy1), 32'd1);
    check("b_no_count", 32'(arr1), 32'h6);
    arrive = 4'b0001;
    tick();
    check("b_idle", 32'(busy1), 32'd0);
    tick();
    check("b_next_gather", 32'(busy1), 32'd1);
    check("b_next_arrived", 32'(arr1), 32'h1);
    check("b_next_norel", 32'(rel1), 32'd0);
    arrive = 4'b1001;
    push_rel(4'h9);
    tick();
    check("b2_release", 32'(rel1), 32'h9);
    tick();
    arrive = 4'h0;
    tick();

    // Timeout with only one of two participants arriving.
    mode    = 1'b0;
    mask    = 4'h3;
    timeout = 16'd10;
    arrive  = 4'b0001;
    push_abort();
    tick();
    check("c_gather", 32'(busy1), 32'd1);
    n = 0;
    while (!abort1 && n < 40) begin
      tick();
      n++;
    end
    check("c_abort_lat", 32'(n), 32'd10);
    check("c_abort_norel", 32'(rel1), 32'd0);
    check("c_abort_phase", 32'(phase1), 32'd3);
    tick();
    check("c_abort_pulse", 32'(abort1), 32'd0);
    check("c_drain", 32'(busy1), 32'd1);
    arrive = 4'h0;
    tick();
    check("c_idle", 32'(busy1), 32'd0);
    timeout = 16'd0;

    // Unmasked ch3 is ignored; ch0 held through DRAIN keeps the FSM there.
    mask   = 4'b0111;
    arrive = 4'b1001;
    tick();
    check("d_arrived", 32'(arr1), 32'h1);
    arrive = 4'b1111;
    push_rel(4'h7);
    tick();
    check("d_release", 32'(rel1), 32'h7);
    check("d_arrived_rel", 32'(arr1), 32'h7);
    check("d_wrap_w2", 32'(phase2), 32'd0);
    tick();
    arrive = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d_drain_hold", 32'(busy1), 32'd1);
    end
    arrive = 4'b1000;
    tick();
    check("d_idle", 32'(busy1), 32'd0);
    tick();
    check("d_unmasked_idle", 32'(busy1), 32'd0);
    check("d_unmasked_arr", 32'(arr1), 32'd0);
    mask   = 4'h0;
    arrive = 4'hF;
    tick();
    check("d_mask0_idle", 32'(busy1), 32'd0);
    arrive = 4'h0;
    tick();

    // Asynchronous reset in the middle of GATHER.
    mask   = 4'hF;
    arrive = 4'b0101;
    tick();
    check("e_arrived", 32'(arr1), 32'h5);
    #2;
    reset = 1'b0;
    #1;
    check("e_rst_arrived", 32'(arr1), 32'd0);
    check("e_rst_busy", 32'(busy1), 32'd0);
    check("e_rst_phase", 32'(phase1), 32'd0);
    check("e_rst_rel", 32'(rel1), 32'd0);
    exp_phase = 8'd0;
    arrive    = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    check("e_quiet", 32'(busy1), 32'd0);

    // Simultaneous arrival of the whole mask releases on the next cycle.
    arrive = 4'hF;
    push_rel(4'hF);
    tick();
    check("f_release", 32'(rel1), 32'hF);
    check("f_phase", 32'(phase1), 32'd1);
    tick();
    arrive = 4'h0;
    tick();

    // Met and timeout in the same cycle: release wins.
    mask    = 4'h3;
    timeout = 16'd2;
    arrive  = 4'b0001;
    tick();
    tick();
    arrive = 4'b0011;
    push_rel(4'h3);
    tick();
    check("g_release", 32'(rel1), 32'h3);
    check("g_noabort", 32'(abort1), 32'd0);
    tick();
    arrive = 4'h0;
    repeat (2) tick();
    timeout = 16'd0;

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
